// File: rtl/platform_collapse_seq.sv
// Frame-synchronous platform collapse sequencer: blinks and then hides segments 0..3 in order.
// State table:  IDLE | all segments shown, waiting for a request
//               BLINK | toggling ctl[idx] every BLINK_FRAMES ticks
//               HOLD | ctl[idx] removed, waiting STEP_FRAMES ticks
//               DONE | all segments hidden until restore
module platform_collapse_seq #(
  parameter int BLINK_FRAMES  = 8,
  parameter int BLINK_TOGGLES = 5,
  parameter int STEP_FRAMES   = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_game,
  input  logic       vblnk,
  input  logic       collapse_req,
  input  logic       restore_req,
  output logic [3:0] ctl,
  output logic       busy,
  output logic       done
);

  localparam int FMAX = (BLINK_FRAMES > STEP_FRAMES) ? BLINK_FRAMES : STEP_FRAMES;
  localparam int FW   = $clog2(FMAX) + 1;
  localparam int TW   = $clog2(BLINK_TOGGLES) + 1;

  typedef enum logic [1:0] {IDLE, BLINK, HOLD, DONE} state_t;

  state_t          state;
  logic            vblnk_q;
  logic            tick;
  logic [FW-1:0]   frame_cnt;
  logic [TW-1:0]   tog_cnt;
  logic [1:0]      idx;

  assign tick = vblnk & ~vblnk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vblnk_q   <= 1'b0;
      frame_cnt <= '0;
      tog_cnt   <= '0;
      idx       <= '0;
      ctl       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      vblnk_q <= vblnk;
      done    <= 1'b0;
      // Dropping start_game overrides ticks, requests and every state.
      if (!start_game) begin
        state     <= IDLE;
        frame_cnt <= '0;
        tog_cnt   <= '0;
        idx       <= '0;
        ctl       <= '0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            ctl  <= '0;
            busy <= 1'b0;
            if (collapse_req) begin
              state     <= BLINK;
              idx       <= '0;
              frame_cnt <= '0;
              tog_cnt   <= '0;
              busy      <= 1'b1;
            end
          end
          BLINK: begin
            if (tick) begin
              if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                tog_cnt   <= tog_cnt + TW'(1);
                if ((tog_cnt + TW'(1)) == TW'(BLINK_TOGGLES)) begin
                  ctl[idx] <= 1'b1;
                  state    <= HOLD;
                end else begin
                  ctl[idx] <= ~ctl[idx];
                end
              end else begin
                frame_cnt <= frame_cnt + FW'(1);
              end
            end
          end
          HOLD: begin
            if (tick) begin
              if (frame_cnt == FW'(STEP_FRAMES - 1)) begin
                frame_cnt <= '0;
                tog_cnt   <= '0;
                if (idx == 2'd3) begin
                  state <= DONE;
                  ctl   <= 4'hF;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  idx   <= idx + 2'd1;
                  state <= BLINK;
                end
              end else begin
                frame_cnt <= frame_cnt + FW'(1);
              end
            end
          end
          DONE: begin
            ctl  <= 4'hF;
            busy <= 1'b0;
            if (restore_req) begin
              state <= IDLE;
              ctl   <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_platform_collapse_seq.sv
// Bench for platform_collapse_seq: directed timeline checks plus randomized traffic
// compared every cycle against a tick-count model of the collapse sequence.
module tb_platform_collapse_seq;

  localparam int BF = 2;
  localparam int BT = 3;
  localparam int SF = 3;
  localparam int P  = BF * BT + SF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_game = 1'b0;
  logic       vblnk = 1'b0;
  logic       collapse_req = 1'b0;
  logic       restore_req = 1'b0;
  logic [3:0] ctl;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  platform_collapse_seq #(
    .BLINK_FRAMES (BF),
    .BLINK_TOGGLES(BT),
    .STEP_FRAMES  (SF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_game  (start_game),
    .vblnk       (vblnk),
    .collapse_req(collapse_req),
    .restore_req (restore_req),
    .ctl         (ctl),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Model: the whole sequence is a function of n, the ticks counted since acceptance.
  function automatic logic [3:0] mask_at(int n);
    logic [3:0] m;
    int k, r, t;
    m = '0;
    k = n / P;
    r = n % P;
    for (int i = 0; i < 4; i++) if (i < k) m[i] = 1'b1;
    if (k < 4) begin
      t = r / BF;
      if (t >= BT) m[k] = 1'b1;
      else m[k] = t[0];
    end
    return m;
  endfunction

  logic       m_vq, m_active, m_indone, allowed;
  int         m_n;
  logic [3:0] exp_ctl;
  logic       exp_busy, exp_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vq = 0; m_active = 0; m_indone = 0; m_n = 0; allowed = 0;
      exp_ctl = '0; exp_busy = 0; exp_done = 0;
    end else begin
      logic tk;
      tk = vblnk & ~m_vq;
      m_vq = vblnk;
      exp_done = 0;
      allowed = tk || !start_game || (m_indone && restore_req);
      if (!start_game) begin
        m_active = 0; m_indone = 0; exp_ctl = '0; exp_busy = 0;
      end else if (m_indone) begin
        exp_ctl = restore_req ? 4'h0 : 4'hF;
        if (restore_req) m_indone = 0;
      end else if (m_active) begin
        if (tk) begin
          m_n++;
          if (m_n == 4 * P) begin
            m_active = 0; m_indone = 1; exp_done = 1; exp_busy = 0; exp_ctl = 4'hF;
          end else begin
            exp_ctl = mask_at(m_n);
          end
        end
      end else begin
        exp_ctl = '0;
        exp_busy = 0;
        if (collapse_req) begin
          m_active = 1; m_n = 0; exp_busy = 1;
        end
      end
    end
  end

  logic [3:0] prev_ctl = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      n_checks += 3;
      if (ctl !== exp_ctl) begin
        n_fail++; $display("FAIL cyc_ctl t=%0t got=%h want=%h", $time, ctl, exp_ctl);
      end
      if (busy !== exp_busy) begin
        n_fail++; $display("FAIL cyc_busy t=%0t got=%b want=%b", $time, busy, exp_busy);
      end
      if (done !== exp_done) begin
        n_fail++; $display("FAIL cyc_done t=%0t got=%b want=%b", $time, done, exp_done);
      end
      if (ctl !== prev_ctl) begin
        n_checks++;
        if (!allowed) begin
          n_fail++; $display("FAIL blank_align t=%0t ctl %h->%h without tick/abort/restore", $time, prev_ctl, ctl);
        end
      end
      prev_ctl = ctl;
    end else begin
      prev_ctl = '0;
    end
  end

  task automatic chk(string name, logic [3:0] act, logic [3:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic tick_frame();
    @(negedge clk) vblnk = 1'b1;
    @(negedge clk) vblnk = 1'b0;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick_frame();
  endtask

  task automatic pulse_collapse();
    @(negedge clk) collapse_req = 1'b1;
    @(negedge clk) collapse_req = 1'b0;
  endtask

  task automatic pulse_restore();
    @(negedge clk) restore_req = 1'b1;
    @(negedge clk) restore_req = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_ctl", ctl, 4'h0);
    chk("reset_busy", {3'b0, busy}, 4'h0);
    chk("reset_done", {3'b0, done}, 4'h0);
    #1 rst_n = 1'b1;

    // Async reset mid-sequence
    start_game = 1'b1;
    pulse_collapse();
    ticks(5);
    chk("pre_reset_ctl", ctl, 4'h0);
    chk("pre_reset_busy", {3'b0, busy}, 4'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", ctl, 4'h0);
    chk("async_rst_busy", {3'b0, busy}, 4'h0);
    chk("async_rst_done", {3'b0, done}, 4'h0);
    @(negedge clk) #1 rst_n = 1'b1;
    ticks(4);
    chk("post_rst_idle_ctl", ctl, 4'h0);
    chk("post_rst_idle_busy", {3'b0, busy}, 4'h0);

    // Full collapse with literal timeline
    pulse_collapse();
    chk("accept_busy", {3'b0, busy}, 4'h1);
    ticks(2);  chk("t2_ctl", ctl, 4'h1);  chk("t2_model", exp_ctl, 4'h1);
    ticks(2);  chk("t4_ctl", ctl, 4'h0);  chk("t4_model", exp_ctl, 4'h0);
    @(negedge clk) collapse_req = 1'b1;
    @(negedge clk) collapse_req = 1'b0;
    ticks(2);  chk("t6_ctl", ctl, 4'h1);  chk("t6_model", exp_ctl, 4'h1);
    @(negedge clk) restore_req = 1'b1;
    @(negedge clk) restore_req = 1'b0;
    ticks(4);  chk("t10_ctl", ctl, 4'h1);
    ticks(1);  chk("t11_ctl", ctl, 4'h3); chk("t11_model", exp_ctl, 4'h3);
    ticks(22); chk("t33_ctl", ctl, 4'hF); chk("t33_busy", {3'b0, busy}, 4'h1);
    ticks(2);  chk("t35_done", {3'b0, done}, 4'h0);
    ticks(1);  chk("t36_done", {3'b0, done}, 4'h1); chk("t36_busy", {3'b0, busy}, 4'h0);
    @(negedge clk);
    chk("t36_done_once", {3'b0, done}, 4'h0);
    chk("done_ctl", ctl, 4'hF);

    // Restore from DONE, then restart from ctl[0]
    pulse_restore();
    chk("restore_ctl", ctl, 4'h0);
    pulse_collapse();
    ticks(2);  chk("restart_t2", ctl, 4'h1);

    // Abort at tick 20 (tick coincident with start_game drop)
    ticks(17); chk("t19_ctl", ctl, 4'h3);
    @(negedge clk) begin vblnk = 1'b1; start_game = 1'b0; end
    @(negedge clk) vblnk = 1'b0;
    chk("abort_ctl", ctl, 4'h0);
    chk("abort_busy", {3'b0, busy}, 4'h0);
    pulse_collapse();
    ticks(3);
    chk("nogame_req_ctl", ctl, 4'h0);
    chk("nogame_req_busy", {3'b0, busy}, 4'h0);

    // Request coincident with a tick
    @(negedge clk) begin start_game = 1'b1; vblnk = 1'b1; collapse_req = 1'b1; end
    @(negedge clk) begin vblnk = 1'b0; collapse_req = 1'b0; end
    chk("coinc_busy", {3'b0, busy}, 4'h1);
    ticks(1);  chk("coinc_t1", ctl, 4'h0);
    ticks(1);  chk("coinc_t2", ctl, 4'h1);

    // Randomized traffic against the model
    for (int c = 0; c < 12000; c++) begin
      @(negedge clk);
      vblnk        = ($urandom_range(0, 2) == 0);
      collapse_req = ($urandom_range(0, 19) == 0);
      restore_req  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 399) == 0) start_game = ~start_game;
      else if (!start_game && $urandom_range(0, 7) == 0) start_game = 1'b1;
    end
    @(negedge clk);
    vblnk = 0; collapse_req = 0; restore_req = 0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
